fifo_rd_stream_adapter: RTL and testbench



---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_rd_skid_buf.sv | 44 ++++
 rtl/fifo_rd_stream_adapter.sv | 58 +++++
 tb/tb_fifo_rd_stream_adapter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, legal depth range and width helper for the FIFO read-side blocks.
package fifo_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int BUF_DEPTH_DEF = 3;
  localparam int BUF_DEPTH_MIN = 2;
  localparam int BUF_DEPTH_MAX = 8;
  localparam int STATS_WIDTH = 32;
  function automatic int cnt_width(input int max_val);
    cnt_width = 1;
    for (int i = 1; i < 31; i++) if (max_val >= (1 << i)) cnt_width = i + 1;
  endfunction
endpackage

// File: rtl/fifo_rd_skid_buf.sv
// fifo_rd_skid_buf: circular prefetch buffer; pointers wrap explicitly so any depth works.
module fifo_rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF,
  localparam int OW = cnt_width(BUF_DEPTH),
  localparam int PW = cnt_width(BUF_DEPTH - 1)
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [OW-1:0]         occ,
  output logic [DATA_WIDTH-1:0] head
);
  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(BUF_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign head = mem[rd_ptr];
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      occ <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      occ <= occ + OW'(push) - OW'(pop);
    end
  end
endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter: FIFO read port to valid/ready stream with prefetch buffering.
// Define FIFO_RD_STATS_EN for a saturating accepted-word counter on word_count.
module fifo_rd_stream_adapter
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic                   rd_clk,
  input  logic                   rst_n,
  output logic                   fifo_rd_en,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   flush,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic [STATS_WIDTH-1:0] word_count
);
  localparam int OW = cnt_width(BUF_DEPTH);
  if (BUF_DEPTH < BUF_DEPTH_MIN || BUF_DEPTH > BUF_DEPTH_MAX) begin : g_bad_depth
    $error("BUF_DEPTH out of range");
  end
  logic [OW-1:0] occ;
  logic inflight, discard, capture, pop;
  // Requests reserve a slot one cycle early, so occ+inflight bounds the buffer; m_ready is not involved.
  assign fifo_rd_en = rst_n && !fifo_empty && !flush && (int'(occ) + int'(inflight) < BUF_DEPTH);
  assign capture = inflight && !discard;
  assign m_valid = occ != '0;
  assign pop = m_valid && m_ready;
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      discard <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      discard <= flush && inflight;
    end
  end
  fifo_rd_skid_buf #(.DATA_WIDTH(DATA_WIDTH), .BUF_DEPTH(BUF_DEPTH)) u_buf (
    .rd_clk(rd_clk),
    .rst_n(rst_n),
    .flush(flush),
    .push(capture),
    .push_data(fifo_rd_data),
    .pop(pop),
    .occ(occ),
    .head(m_data)
  );
`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) word_count <= '0;
    else if (pop && !flush && word_count != '1) word_count <= word_count + 1'b1;
  end
`else
  assign word_count = '0;
`endif
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// tb_fifo_rd_stream_adapter: directed bench with a registered-read FIFO model driving the adapter.
module tb_fifo_rd_stream_adapter;
  logic rd_clk, rst_n, fifo_rd_en, fifo_empty, flush, m_valid, m_ready;
  logic [7:0] fifo_rd_data, m_data;
  logic [31:0] word_count;
  logic s_rd_en, s_valid, hs, have_data;
  logic [7:0] s_data, base, nxt_data;
  int sidx, ridx, src_n, checks, failures;
`ifdef FIFO_RD_STATS_EN
  localparam int WC10 = 10;
`else
  localparam int WC10 = 0;
`endif

  fifo_rd_stream_adapter dut (
    .rd_clk(rd_clk), .rst_n(rst_n), .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .word_count(word_count)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  task automatic rst_assert();
    rst_n = 1'b0;
    m_ready = 1'b0;
    flush = 1'b0;
    sidx = 0;
    ridx = 0;
    have_data = 1'b0;
    fifo_empty = (src_n == 0);
    fifo_rd_data = 8'h00;
    #1;
  endtask

  task automatic rst_release();
    @(posedge rd_clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One read-clock cycle: entered and left 1 time unit after a rising edge.
  task automatic cyc(input logic rdy, input logic fl, input logic gate);
    m_ready = rdy;
    flush = fl;
    fifo_rd_data = have_data ? nxt_data : 8'hA5;
    have_data = 1'b0;
    fifo_empty = gate || (sidx >= src_n);
    #1;
    s_rd_en = fifo_rd_en;
    s_valid = m_valid;
    s_data = m_data;
    hs = m_valid && m_ready && !flush;
    if (fifo_rd_en && !fifo_empty) begin
      nxt_data = base + 8'(sidx);
      sidx++;
      have_data = 1'b1;
    end
    @(posedge rd_clk);
    #1;
  endtask

  task automatic test_reset();
    base = 8'h11;
    src_n = 100;
    rst_assert();
    checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL rst_rd_en: got %b want 0", fifo_rd_en); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    checks++; if (m_data !== 8'h00) begin failures++; $display("FAIL rst_m_data: got %h want 00", m_data); end
    checks++; if (word_count !== 32'd0) begin failures++; $display("FAIL rst_word_count: got %0d want 0", word_count); end
    rst_release();
    cyc(1'b1, 1'b0, 1'b0);
    checks++; if (s_rd_en !== 1'b1) begin failures++; $display("FAIL lat_rd_en_c0: got %b want 1", s_rd_en); end
    checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL lat_valid_c0: got %b want 0", s_valid); end
    cyc(1'b1, 1'b0, 1'b0);
    checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL lat_valid_c1: got %b want 0", s_valid); end
    cyc(1'b1, 1'b0, 1'b0);
    checks++; if (s_valid !== 1'b1) begin failures++; $display("FAIL lat_valid_c2: got %b want 1", s_valid); end
    checks++; if (s_data !== 8'h11) begin failures++; $display("FAIL lat_data_c2: got %h want 11", s_data); end
    cyc(1'b0, 1'b0, 1'b0);
    rst_assert();
    checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL midrst_rd_en: got %b want 0", fifo_rd_en); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL midrst_m_valid: got %b want 0", m_valid); end
    rst_release();
  endtask

  task automatic test_back_to_back();
    int gaps;
    logic first;
    gaps = 0;
    first = 1'b0;
    base = 8'h00;
    src_n = 16;
    rst_assert();
    rst_release();
    for (int i = 0; i < 40 && ridx < 16; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (hs) begin
        checks++; if (s_data !== 8'(ridx)) begin failures++; $display("FAIL b2b_data[%0d]: got %h want %h", ridx, s_data, 8'(ridx)); end
        ridx++;
        first = 1'b1;
      end else if (first) gaps++;
    end
    checks++; if (ridx !== 16) begin failures++; $display("FAIL b2b_count: got %0d want 16", ridx); end
    checks++; if (gaps !== 0) begin failures++; $display("FAIL b2b_gaps: got %0d want 0", gaps); end
  endtask

  task automatic test_backpressure();
    base = 8'h00;
    src_n = 100;
    rst_assert();
    rst_release();
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0);
    checks++; if (sidx !== 3) begin failures++; $display("FAIL bp_requests: got %0d want 3", sidx); end
    checks++; if (s_rd_en !== 1'b0) begin failures++; $display("FAIL bp_rd_en: got %b want 0", s_rd_en); end
    checks++; if (s_valid !== 1'b1) begin failures++; $display("FAIL bp_valid: got %b want 1", s_valid); end
    checks++; if (s_data !== 8'h00) begin failures++; $display("FAIL bp_hold_data: got %h want 00", s_data); end
    for (int i = 0; i < 20 && ridx < 6; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (hs) begin
        checks++; if (s_data !== 8'(ridx)) begin failures++; $display("FAIL bp_release[%0d]: got %h want %h", ridx, s_data, 8'(ridx)); end
        ridx++;
      end
    end
    checks++; if (ridx !== 6) begin failures++; $display("FAIL bp_release_count: got %0d want 6", ridx); end
  endtask

  task automatic test_flush();
    logic got;
    got = 1'b0;
    base = 8'h40;
    src_n = 100;
    rst_assert();
    rst_release();
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    checks++; if (s_rd_en !== 1'b0) begin failures++; $display("FAIL flush_rd_en: got %b want 0", s_rd_en); end
    checks++; if (s_valid !== 1'b1) begin failures++; $display("FAIL flush_pre_valid: got %b want 1", s_valid); end
    cyc(1'b0, 1'b0, 1'b0);
    checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b want 0", s_valid); end
    for (int i = 0; i < 10 && !got; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (hs) begin
        got = 1'b1;
        checks++; if (s_data !== 8'h43) begin failures++; $display("FAIL flush_next_data: got %h want 43", s_data); end
      end
    end
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL flush_resume: got no word want 43"); end
  endtask

  task automatic test_random();
    base = 8'h00;
    src_n = 1000;
    rst_assert();
    rst_release();
    for (int i = 0; i < 20000 && ridx < 1000; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 2) == 0);
      if (hs) begin
        checks++; if (s_data !== 8'(ridx)) begin failures++; $display("FAIL rand_data[%0d]: got %h want %h", ridx, s_data, 8'(ridx)); end
        ridx++;
      end
      checks++; if (sidx - ridx > 3) begin failures++; $display("FAIL rand_occupancy: got %0d want <=3", sidx - ridx); end
    end
    checks++; if (ridx !== 1000) begin failures++; $display("FAIL rand_count: got %0d want 1000", ridx); end
  endtask

  task automatic test_stats();
    logic got;
    got = 1'b0;
    base = 8'h00;
    src_n = 10;
    rst_assert();
    rst_release();
    for (int i = 0; i < 40 && ridx < 10; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (hs) ridx++;
    end
    checks++; if (word_count !== 32'(WC10)) begin failures++; $display("FAIL stats_count10: got %0d want %0d", word_count, WC10); end
    src_n = 20;
    for (int i = 0; i < 10 && !got; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      got = s_valid;
    end
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL stats_refill: got no valid want valid"); end
    cyc(1'b1, 1'b1, 1'b0);
    checks++; if (word_count !== 32'(WC10)) begin failures++; $display("FAIL stats_flush_hs: got %0d want %0d", word_count, WC10); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL stats_flush_valid: got %b want 0", m_valid); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    src_n = 0;
    base = 8'h00;
    nxt_data = 8'h00;
    m_ready = 1'b0;
    flush = 1'b0;
    rst_n = 1'b0;
    fifo_empty = 1'b1;
    fifo_rd_data = 8'h00;
    @(posedge rd_clk);
    #1;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_random();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
